// File: rtl/rsa_crt_decrypt.sv
// rsa_crt_decrypt: RSA decryption with the Chinese Remainder Theorem, m = c^d mod p*q.
// The fixed-latency sequence is:
//   reduce c by p, reduce c by q,
//   constant-time exponentiation mod p and mod q,
//   Garner recombination.
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-low reset
//   start            - request, sampled only in IDLE
//   c                - ciphertext (2*P_BIT), c < p*q
//   p, q             - odd primes (P_BIT each), p > q
//   dp, dq, qinv     - CRT private exponents and q^-1 mod p (P_BIT each)
//   busy             - operation in progress (including the DONE cycle)
//   done             - one-cycle pulse when m is updated
//   m                - plaintext (2*P_BIT), held until the next result
module rsa_crt_decrypt #(
  parameter int unsigned P_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*P_BIT-1:0]   c,
  input  logic [P_BIT-1:0]     p,
  input  logic [P_BIT-1:0]     q,
  input  logic [P_BIT-1:0]     dp,
  input  logic [P_BIT-1:0]     dq,
  input  logic [P_BIT-1:0]     qinv,
  output logic                 busy,
  output logic                 done,
  output logic [2*P_BIT-1:0]   m
);

  localparam int unsigned W  = 2 * P_BIT;
  localparam int unsigned RW = P_BIT + 1;
  localparam int unsigned MW = P_BIT + 2;
  localparam int unsigned CW = $clog2(2 * P_BIT);
  localparam int unsigned EW = (P_BIT > 1) ? $clog2(P_BIT) : 1;
  localparam logic [P_BIT-1:0] P_MSB = P_BIT'(1) << (P_BIT - 1);
  localparam logic [W-1:0]     W_MSB = W'(1) << (W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RED_P, S_RED_Q, S_EXP_P, S_EXP_Q, S_SUB, S_HMUL, S_COMB, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Captured operands
  logic [W-1:0]     c_r;
  logic [P_BIT-1:0] p_r, q_r, dp_r, dq_r, qinv_r;

  // Datapath state
  logic [CW-1:0]    cnt;      // bit index within a reduction / multiply
  logic [EW-1:0]    ebit;     // exponent bit index, MSB first
  logic             phase;    // 0: squaring, 1: multiply by base
  logic [P_BIT-1:0] rem;
  logic [MW-1:0]    acc;
  logic [P_BIT-1:0] x;        // exponentiation accumulator
  logic [P_BIT-1:0] cp, cq, mp, mq, dlt, h;
  logic [W-1:0]     m_acc;

  // Control flags
  logic last_red, last_mm, last_bit;

  assign last_red = (cnt == CW'(W - 1));
  assign last_mm  = (cnt == CW'(P_BIT - 1));
  assign last_bit = (ebit == EW'(P_BIT - 1));

  // Restoring reduction step: shift in the next bit of c, subtract the modulus if it fits
  logic [P_BIT-1:0] red_mod;
  logic             c_bit;
  logic [RW-1:0]    rem_sh;
  logic [P_BIT-1:0] rem_nxt;

  always_comb begin
    red_mod = (state_q == S_RED_Q) ? q_r : p_r;
    c_bit   = |(c_r & (W_MSB >> cnt));
    rem_sh  = {rem, c_bit};
    rem_nxt = P_BIT'((rem_sh >= RW'(red_mod)) ? (rem_sh - RW'(red_mod)) : rem_sh);
  end

  // Shared interleaved modular multiply step: acc = 2*acc + b_i*a, then up to two subtractions
  logic [P_BIT-1:0] mm_a, mm_b, mm_n;
  logic             mm_bit;
  logic [MW-1:0]    mm_t0, mm_t1, mm_t2;
  logic [P_BIT-1:0] mm_res;

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    mm_n = '0;
    case (state_q)
      S_EXP_P: begin
        mm_a = x;
        mm_b = phase ? cp : x;
        mm_n = p_r;
      end
      S_EXP_Q: begin
        mm_a = x;
        mm_b = phase ? cq : x;
        mm_n = q_r;
      end
      S_HMUL: begin
        mm_a = dlt;
        mm_b = qinv_r;
        mm_n = p_r;
      end
      default: ;
    endcase
    mm_bit = |(mm_b & (P_MSB >> cnt));
    mm_t0  = (acc << 1) + (mm_bit ? MW'(mm_a) : MW'(0));
    mm_t1  = (mm_t0 >= MW'(mm_n)) ? (mm_t0 - MW'(mm_n)) : mm_t0;
    mm_t2  = (mm_t1 >= MW'(mm_n)) ? (mm_t1 - MW'(mm_n)) : mm_t1;
    mm_res = P_BIT'(mm_t2);
  end

  // Current exponent bit; the product is kept only when it is set
  logic [P_BIT-1:0] e_op;
  logic             e_bit;

  always_comb begin
    e_op  = (state_q == S_EXP_Q) ? dq_r : dp_r;
    e_bit = |(e_op & (P_MSB >> ebit));
  end

  // Garner difference; wraps mod 2^P_BIT harmlessly since the true result is < p
  logic [P_BIT-1:0] dlt_nxt;
  assign dlt_nxt = (mp >= mq) ? (mp - mq) : (mp + p_r - mq);

  // Recombination: add q shifted by the weight of the current bit of h
  logic          h_bit;
  logic [W-1:0]  comb_add, m_acc_nxt;

  always_comb begin
    h_bit     = |(h & (P_MSB >> cnt));
    comb_add  = h_bit ? (W'(q_r) << (CW'(P_BIT - 1) - cnt)) : W'(0);
    m_acc_nxt = m_acc + comb_add;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)                      state_d = S_RED_P;
      S_RED_P: if (last_red)                   state_d = S_RED_Q;
      S_RED_Q: if (last_red)                   state_d = S_EXP_P;
      S_EXP_P: if (last_mm && phase && last_bit) state_d = S_EXP_Q;
      S_EXP_Q: if (last_mm && phase && last_bit) state_d = S_SUB;
      S_SUB:                                   state_d = S_HMUL;
      S_HMUL:  if (last_mm)                    state_d = S_COMB;
      S_COMB:  if (last_mm)                    state_d = S_DONE;
      S_DONE:                                  state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_r    <= '0;
      p_r    <= '0;
      q_r    <= '0;
      dp_r   <= '0;
      dq_r   <= '0;
      qinv_r <= '0;
      cnt    <= '0;
      ebit   <= '0;
      phase  <= 1'b0;
      rem    <= '0;
      acc    <= '0;
      x      <= '0;
      cp     <= '0;
      cq     <= '0;
      mp     <= '0;
      mq     <= '0;
      dlt    <= '0;
      h      <= '0;
      m_acc  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            c_r    <= c;
            p_r    <= p;
            q_r    <= q;
            dp_r   <= dp;
            dq_r   <= dq;
            qinv_r <= qinv;
            cnt    <= '0;
            rem    <= '0;
          end
        end
        S_RED_P, S_RED_Q: begin
          if (last_red) begin
            cnt <= '0;
            rem <= '0;
            if (state_q == S_RED_P) begin
              cp <= rem_nxt;
            end else begin
              cq    <= rem_nxt;
              x     <= P_BIT'(1);
              acc   <= '0;
              phase <= 1'b0;
              ebit  <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
            rem <= rem_nxt;
          end
        end
        S_EXP_P, S_EXP_Q: begin
          if (last_mm) begin
            cnt <= '0;
            acc <= '0;
            if (!phase) begin
              x     <= mm_res;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (last_bit) begin
                // Finished this exponentiation; restart the accumulator for the next one
                ebit <= '0;
                x    <= P_BIT'(1);
                if (state_q == S_EXP_P) mp <= e_bit ? mm_res : x;
                else                    mq <= e_bit ? mm_res : x;
              end else begin
                ebit <= ebit + EW'(1);
                if (e_bit) x <= mm_res;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
            acc <= mm_t2;
          end
        end
        S_SUB: begin
          dlt   <= dlt_nxt;
          m_acc <= W'(mq);
          cnt   <= '0;
          acc   <= '0;
        end
        S_HMUL: begin
          if (last_mm) begin
            h   <= mm_res;
            cnt <= '0;
            acc <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            acc <= mm_t2;
          end
        end
        S_COMB: begin
          m_acc <= m_acc_nxt;
          cnt   <= last_mm ? CW'(0) : (cnt + CW'(1));
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; m and done update on the edge that enters DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      m    <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      if (state_q == S_COMB && state_d == S_DONE) m <= m_acc_nxt;
    end
  end

endmodule
